ycbcr2rgb: RTL and testbench

Pipelined YCbCr 4:4:4 to RGB565 converter. It is the inverse of the camera-path RGB565→YCbCr stage, and is used to return processed luma/chroma to the LCD/HDMI display path. Video timing signals (vsync/hsync/de) are delayed to stay aligned with the pixel data. Both full-precision RGB888 and packed RGB565 outputs are provided.

---
 rtl/ycbcr2rgb.sv | 110 +++++++++++
 tb/tb_ycbcr2rgb.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/ycbcr2rgb.sv
// YCbCr 4:4:4 -> RGB888/RGB565 converter with video sync delay; 4-cycle latency, 1 pixel/clk.
// No backpressure: the pipeline free-runs and sync/de ride alongside the pixel data.
module ycbcr2rgb #(
  parameter bit GATE_HSYNC = 1'b1,
  parameter bit ROUND_EN   = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pre_frame_vsync,
  input  logic       pre_frame_hsync,
  input  logic       pre_frame_de,
  input  logic [7:0] img_y,
  input  logic [7:0] img_cb,
  input  logic [7:0] img_cr,
  output logic       post_frame_vsync,
  output logic       post_frame_hsync,
  output logic       post_frame_de,
  output logic [7:0] img_r8,
  output logic [7:0] img_g8,
  output logic [7:0] img_b8,
  output logic [4:0] img_red,
  output logic [5:0] img_green,
  output logic [4:0] img_blue
);

  localparam logic signed [19:0] K = ROUND_EN ? 20'sd128 : 20'sd0;

  logic [7:0]         y1;
  logic signed [8:0]  cb1, cr1;
  logic [15:0]        y2;
  logic signed [17:0] r_cr2, g_cb2, g_cr2, b_cb2;
  logic signed [19:0] r3, g3, b3;
  logic [7:0]         r4, g4, b4;
  logic [3:0]         vs_sr, hs_sr, de_sr;
  logic               gate_off;

  function automatic logic signed [17:0] sx18(input logic signed [8:0] v);
    return {{9{v[8]}}, v};
  endfunction

  function automatic logic signed [19:0] sx20(input logic signed [17:0] v);
    return {{2{v[17]}}, v};
  endfunction

  // Sums are never out of 20-bit range, so only the final 8-bit saturation is needed.
  function automatic logic [7:0] clamp8(input logic signed [19:0] s);
    logic signed [19:0] sh;
    sh = s >>> 8;
    if (sh < 20'sd0) return 8'd0;
    if (sh > 20'sd255) return 8'hff;
    return sh[7:0];
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y1    <= '0;
      cb1   <= '0;
      cr1   <= '0;
      y2    <= '0;
      r_cr2 <= '0;
      g_cb2 <= '0;
      g_cr2 <= '0;
      b_cb2 <= '0;
      r3    <= '0;
      g3    <= '0;
      b3    <= '0;
      r4    <= '0;
      g4    <= '0;
      b4    <= '0;
      vs_sr <= '0;
      hs_sr <= '0;
      de_sr <= '0;
    end else begin
      y1    <= img_y;
      cb1   <= $signed({1'b0, img_cb}) - 9'sd128;
      cr1   <= $signed({1'b0, img_cr}) - 9'sd128;

      y2    <= {y1, 8'd0};
      r_cr2 <= sx18(cr1) * 18'sd359;
      g_cb2 <= sx18(cb1) * 18'sd88;
      g_cr2 <= sx18(cr1) * 18'sd183;
      b_cb2 <= sx18(cb1) * 18'sd454;

      r3    <= $signed({4'd0, y2}) + sx20(r_cr2) + K;
      g3    <= $signed({4'd0, y2}) - sx20(g_cb2) - sx20(g_cr2) + K;
      b3    <= $signed({4'd0, y2}) + sx20(b_cb2) + K;

      r4    <= clamp8(r3);
      g4    <= clamp8(g3);
      b4    <= clamp8(b3);

      vs_sr <= {vs_sr[2:0], pre_frame_vsync};
      hs_sr <= {hs_sr[2:0], pre_frame_hsync};
      de_sr <= {de_sr[2:0], pre_frame_de};
    end
  end

  assign post_frame_vsync = vs_sr[3];
  assign post_frame_hsync = hs_sr[3];
  assign post_frame_de    = de_sr[3];

  assign gate_off  = GATE_HSYNC && !hs_sr[3];
  assign img_r8    = gate_off ? 8'd0 : r4;
  assign img_g8    = gate_off ? 8'd0 : g4;
  assign img_b8    = gate_off ? 8'd0 : b4;
  assign img_red   = img_r8[7:3];
  assign img_green = img_g8[7:2];
  assign img_blue  = img_b8[7:3];

endmodule

// File: tb/tb_ycbcr2rgb.sv
// Bench for ycbcr2rgb: three instances cover ROUND_EN and GATE_HSYNC settings.
module tb_ycbcr2rgb;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       vs, hs, de;
  logic [7:0] y, cb, cr;

  logic       a_vs, a_hs, a_de, b_vs, b_hs, b_de, c_vs, c_hs, c_de;
  logic [7:0] a_r8, a_g8, a_b8, b_r8, b_g8, b_b8, c_r8, c_g8, c_b8;
  logic [4:0] a_red, a_blue, b_red, b_blue, c_red, c_blue;
  logic [5:0] a_green, b_green, c_green;
  logic [42:0] a_out, b_out, c_out;

  assign a_out = {a_vs, a_hs, a_de, a_r8, a_g8, a_b8, a_red, a_green, a_blue};
  assign b_out = {b_vs, b_hs, b_de, b_r8, b_g8, b_b8, b_red, b_green, b_blue};
  assign c_out = {c_vs, c_hs, c_de, c_r8, c_g8, c_b8, c_red, c_green, c_blue};

  ycbcr2rgb #(.GATE_HSYNC(1'b1), .ROUND_EN(1'b1)) dut_a (
    .clk(clk), .rst(rst), .pre_frame_vsync(vs), .pre_frame_hsync(hs), .pre_frame_de(de),
    .img_y(y), .img_cb(cb), .img_cr(cr),
    .post_frame_vsync(a_vs), .post_frame_hsync(a_hs), .post_frame_de(a_de),
    .img_r8(a_r8), .img_g8(a_g8), .img_b8(a_b8),
    .img_red(a_red), .img_green(a_green), .img_blue(a_blue));

  ycbcr2rgb #(.GATE_HSYNC(1'b1), .ROUND_EN(1'b0)) dut_b (
    .clk(clk), .rst(rst), .pre_frame_vsync(vs), .pre_frame_hsync(hs), .pre_frame_de(de),
    .img_y(y), .img_cb(cb), .img_cr(cr),
    .post_frame_vsync(b_vs), .post_frame_hsync(b_hs), .post_frame_de(b_de),
    .img_r8(b_r8), .img_g8(b_g8), .img_b8(b_b8),
    .img_red(b_red), .img_green(b_green), .img_blue(b_blue));

  ycbcr2rgb #(.GATE_HSYNC(1'b0), .ROUND_EN(1'b1)) dut_c (
    .clk(clk), .rst(rst), .pre_frame_vsync(vs), .pre_frame_hsync(hs), .pre_frame_de(de),
    .img_y(y), .img_cb(cb), .img_cr(cr),
    .post_frame_vsync(c_vs), .post_frame_hsync(c_hs), .post_frame_de(c_de),
    .img_r8(c_r8), .img_g8(c_g8), .img_b8(c_b8),
    .img_red(c_red), .img_green(c_green), .img_blue(c_blue));

  typedef struct packed {
    logic       vld;
    logic       vs;
    logic       hs;
    logic       de;
    logic [7:0] y;
    logic [7:0] cb;
    logic [7:0] cr;
  } pix_t;

  typedef struct {
    logic [7:0]  y, cb, cr;
    logic [23:0] rgb_rnd;
    logic [23:0] rgb_trunc;
  } vec_t;

  int   n_checks = 0;
  int   n_fail   = 0;
  pix_t q[$];
  vec_t tbl[4];

  task automatic check(input string name, input logic [42:0] act, input logic [42:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] chan(input int v);
    if (v < 0) return 8'd0;
    if (v / 256 > 255) return 8'd255;
    return 8'(v / 256);
  endfunction

  // Reference: real-number formulas in integer form, floored then saturated.
  function automatic logic [42:0] model(input pix_t p, input bit rnd, input bit gate);
    int yi, cbs, crs, k;
    logic [7:0] r, g, b;
    if (!p.vld) return '0;
    yi  = int'(p.y);
    cbs = int'(p.cb) - 128;
    crs = int'(p.cr) - 128;
    k   = rnd ? 128 : 0;
    r = chan(256 * yi + 359 * crs + k);
    g = chan(256 * yi - 88 * cbs - 183 * crs + k);
    b = chan(256 * yi + 454 * cbs + k);
    if (gate && !p.hs) begin
      r = '0; g = '0; b = '0;
    end
    return {p.vs, p.hs, p.de, r, g, b, r[7:3], g[7:2], b[7:3]};
  endfunction

  function automatic pix_t rnd_pix(input int i);
    pix_t p;
    p.vld = 1'b1;
    p.hs  = (i % 20) >= 4;
    p.de  = p.hs && ((i % 20) < 18);
    p.vs  = (i % 150) < 2;
    p.y   = 8'(i * 7);
    p.cb  = 8'($urandom);
    p.cr  = 8'($urandom);
    if (i % 5 == 0) begin
      p.cb = ($urandom % 2) ? 8'd0 : 8'd255;
      p.cr = ($urandom % 2) ? 8'd0 : 8'd255;
    end
    return p;
  endfunction

  task automatic drive(input pix_t p);
    vs = p.vs; hs = p.hs; de = p.de;
    y = p.y; cb = p.cb; cr = p.cr;
  endtask

  // One pixel per clock: compare the pixel that entered 4 clocks ago, then feed the next.
  task automatic step(input pix_t nx);
    pix_t e;
    @(negedge clk);
    e = q.pop_front();
    check("pipe_round_gate", a_out, model(e, 1'b1, 1'b1));
    check("pipe_trunc_gate", b_out, model(e, 1'b0, 1'b1));
    check("pipe_round_nogate", c_out, model(e, 1'b1, 1'b0));
    drive(nx);
    q.push_back(nx);
  endtask

  initial begin
    pix_t p;
    logic [42:0] exp_a, exp_b;

    tbl[0] = '{8'd128, 8'd128, 8'd128, {8'd128, 8'd128, 8'd128}, {8'd128, 8'd128, 8'd128}};
    tbl[1] = '{8'd255, 8'd128, 8'd255, {8'd255, 8'd164, 8'd255}, {8'd255, 8'd164, 8'd255}};
    tbl[2] = '{8'd0,   8'd0,   8'd0,   {8'd0,   8'd136, 8'd0},   {8'd0,   8'd135, 8'd0}};
    tbl[3] = '{8'd81,  8'd90,  8'd240, {8'd238, 8'd14,  8'd14},  {8'd238, 8'd14,  8'd13}};

    p = '0;
    drive(p);
    #3;
    check("reset_state_a", a_out, '0);
    check("reset_state_b", b_out, '0);
    check("reset_state_c", c_out, '0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      p = '{1'b1, 1'b0, 1'b1, 1'b1, tbl[i].y, tbl[i].cb, tbl[i].cr};
      drive(p);
      repeat (4) @(posedge clk);
      #1;
      exp_a = {3'b011, tbl[i].rgb_rnd, tbl[i].rgb_rnd[23:19], tbl[i].rgb_rnd[15:10],
               tbl[i].rgb_rnd[7:3]};
      exp_b = {3'b011, tbl[i].rgb_trunc, tbl[i].rgb_trunc[23:19], tbl[i].rgb_trunc[15:10],
               tbl[i].rgb_trunc[7:3]};
      check("vector_round", a_out, exp_a);
      check("vector_trunc", b_out, exp_b);
      check("vector_nogate", c_out, exp_a);
    end

    q = {};
    for (int i = 0; i < 4; i++) q.push_back(p);
    for (int i = 0; i < 300; i++) step(rnd_pix(i));

    // Asynchronous reset between edges, mid-line.
    #2 rst = 1'b1;
    #1;
    check("async_reset_a", a_out, '0);
    check("async_reset_b", b_out, '0);
    check("async_reset_c", c_out, '0);
    foreach (q[j]) q[j].vld = 1'b0;
    repeat (3) step(pix_t'(0));

    p = '{1'b1, 1'b0, 1'b0, 1'b0, 8'd200, 8'd30, 8'd220};
    step(p);
    rst = 1'b0;
    step(p);
    p = '{1'b1, 1'b0, 1'b1, 1'b1, 8'd128, 8'd128, 8'd128};
    step(p);
    for (int i = 300; i < 360; i++) step(rnd_pix(i));
    for (int i = 0; i < 4; i++) step(pix_t'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
